// File: rtl/fixed_float_pkg.sv
// Shared FP32 field constants, the packed float layout and the converter state encoding.
package fixed_float_pkg;

  localparam int FP32_BIAS   = 127;
  localparam int FP32_EXP_W  = 8;
  localparam int FP32_MANT_W = 23;

  typedef struct packed {
    logic                   sign;
    logic [FP32_EXP_W-1:0]  exponent;
    logic [FP32_MANT_W-1:0] mantissa;
  } fp32_t;

  typedef enum logic [1:0] {IDLE, NORM, DONE} conv_state_t;

  function automatic fp32_t fp32_pack(input logic s, input logic [FP32_EXP_W-1:0] e,
                                      input logic [FP32_MANT_W-1:0] m);
    fp32_t f;
    f.sign     = s;
    f.exponent = e;
    f.mantissa = m;
    return f;
  endfunction

endpackage

// File: rtl/fixed_lzc.sv
// Leading-zero counter over a FIXED_W-bit magnitude; an all-zero input counts FIXED_W.
module fixed_lzc #(
  parameter int FIXED_W = 16,
  parameter int CNT_W   = $clog2(FIXED_W) + 1
) (
  input  logic [FIXED_W-1:0] mag_i,
  output logic [CNT_W-1:0]   lz_o
);

  // Scan upward so the highest set bit is the last one to write the count.
  always_comb begin
    lz_o = CNT_W'(FIXED_W);
    for (int i = 0; i < FIXED_W; i++) begin
      if (mag_i[i]) lz_o = CNT_W'(FIXED_W - 1 - i);
    end
  end

endmodule

// File: rtl/fixed_to_float.sv
// Signed integer to IEEE-754 single converter with an iterative normalizing shifter.
// Define FIXED_TO_FLOAT_LZC_EN to replace the shifter with a one-cycle leading-zero count.
module fixed_to_float
  import fixed_float_pkg::*;
#(
  parameter int FIXED_W = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [FIXED_W-1:0] i_fixed,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [31:0]        o_float
);

  localparam logic [FP32_EXP_W-1:0] EXP_TOP = FP32_EXP_W'(FP32_BIAS + FIXED_W - 1);
  localparam int                    MSB     = FIXED_W - 1;

  conv_state_t               state_q, state_d;
  logic                      sign_q, sign_d;
  logic [FIXED_W-1:0]        shreg_q, shreg_d;
  logic [FP32_EXP_W-1:0]     exp_q, exp_d;
  fp32_t                     float_q, float_d;
  logic [FIXED_W-1:0]        mag;
  logic                      accept;
  logic                      mag_zero;

  assign accept   = (state_q == IDLE) && i_valid;
  assign mag      = i_fixed[MSB] ? (~i_fixed) + {{(FIXED_W-1){1'b0}}, 1'b1} : i_fixed;
  assign mag_zero = (mag == '0);

  // Bits below the leading one, left-aligned into the 23-bit mantissa field.
  function automatic logic [FP32_MANT_W-1:0] mant_align(input logic [FIXED_W-1:0] v);
    logic [FP32_MANT_W-1:0] m;
    m = '0;
    m[FP32_MANT_W-1 -: FIXED_W-1] = v[FIXED_W-2:0];
    return m;
  endfunction

`ifdef FIXED_TO_FLOAT_LZC_EN
  localparam int CNT_W = $clog2(FIXED_W) + 1;
  logic [CNT_W-1:0] lz;

  fixed_lzc #(.FIXED_W(FIXED_W), .CNT_W(CNT_W)) u_lzc (
    .mag_i (mag),
    .lz_o  (lz)
  );
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // The first normalize step is folded into the accept edge, so a leading one
  // at bit p reaches DONE after FIXED_W-p edges.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef FIXED_TO_FLOAT_LZC_EN
          state_d = DONE;
`else
          state_d = (mag_zero || mag[MSB]) ? DONE : NORM;
`endif
        end
      end
      NORM:    state_d = shreg_q[MSB] ? DONE : NORM;
      DONE:    state_d = i_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_ready = (state_q == IDLE);
    o_valid = (state_q == DONE);
    o_float = float_q;
  end

  always_comb begin
    sign_d  = sign_q;
    shreg_d = shreg_q;
    exp_d   = exp_q;
    float_d = float_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          sign_d = i_fixed[MSB];
`ifdef FIXED_TO_FLOAT_LZC_EN
          if (mag_zero) float_d = '0;
          else          float_d = fp32_pack(i_fixed[MSB], EXP_TOP - FP32_EXP_W'(lz),
                                            mant_align(mag << lz));
`else
          if (mag_zero) begin
            float_d = '0;
          end else if (mag[MSB]) begin
            float_d = fp32_pack(i_fixed[MSB], EXP_TOP, mant_align(mag));
          end else begin
            shreg_d = mag << 1;
            exp_d   = EXP_TOP - 8'd1;
          end
`endif
        end
      end
      NORM: begin
        if (shreg_q[MSB]) begin
          float_d = fp32_pack(sign_q, exp_q, mant_align(shreg_q));
        end else begin
          shreg_d = shreg_q << 1;
          exp_d   = exp_q - 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sign_q  <= 1'b0;
      shreg_q <= '0;
      exp_q   <= '0;
      float_q <= '0;
    end else begin
      sign_q  <= sign_d;
      shreg_q <= shreg_d;
      exp_q   <= exp_d;
      float_q <= float_d;
    end
  end

endmodule

// File: tb/tb_fixed_to_float.sv
// Directed bench for fixed_to_float: values, latency, backpressure and async reset abort.
module tb_fixed_to_float;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         out_ready;
  logic [W-1:0] in_fixed;
  logic         out_valid;
  logic         in_ready;
  logic [31:0]  out_float;

  int n_checks = 0;
  int n_err    = 0;

  fixed_to_float #(.FIXED_W(W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (in_valid),
    .o_ready (out_ready),
    .i_fixed (in_fixed),
    .o_valid (out_valid),
    .i_ready (in_ready),
    .o_float (out_float)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int exp_lat(input int p);
`ifdef FIXED_TO_FLOAT_LZC_EN
    return 1;
`else
    return (p < 0) ? 1 : W - p;
`endif
  endfunction

  // Drive one sample with i_ready high; p is the leading-one position of |v| (-1 for zero).
  task automatic conv(input string tag, input logic [W-1:0] v, input logic [31:0] expf,
                      input int p);
    int lat;
    @(negedge clk);
    chk({tag, "_ready"}, 32'(out_ready), 32'd1);
    in_valid = 1'b1;
    in_fixed = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_fixed = ~v;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat(p)));
    chk({tag, "_float"}, out_float, expf);
    @(posedge clk); #1;
    chk({tag, "_idle"}, {30'd0, out_valid, out_ready}, 32'b01);
    chk({tag, "_hold"}, out_float, expf);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_fixed = '0;
    in_ready = 1'b1;
    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(out_ready), 32'd1);
    chk("rst_float", out_float, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    conv("one",    16'd1,     32'h3F80_0000, 0);
    conv("neg1",   16'hFFFF,  32'hBF80_0000, 0);
    conv("twelve", 16'd12,    32'h4140_0000, 3);
    conv("hundred",16'd100,   32'h42C8_0000, 6);
    conv("minneg", 16'h8000,  32'hC700_0000, 15);
    conv("maxpos", 16'h7FFF,  32'h46FF_FE00, 14);
    conv("zero",   16'd0,     32'h0000_0000, -1);
    conv("neg100", 16'hFF9C,  32'hC2C8_0000, 6);

    // Backpressure: result must sit still while downstream stalls.
    begin
      int lat;
      in_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b1;
      in_fixed = 16'd12;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 40) begin
        @(posedge clk); #1;
        lat++;
      end
      chk("bp_lat", 32'(lat), 32'(exp_lat(3)));
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        in_valid = ~in_valid;
        in_fixed = 16'($urandom);
        @(posedge clk); #1;
        chk("bp_state", {29'd0, out_valid, out_ready, 1'b0}, 32'b100);
        chk("bp_float", out_float, 32'h4140_0000);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release", {30'd0, out_valid, out_ready}, 32'b01);
      chk("bp_keep", out_float, 32'h4140_0000);
    end

    // Reset mid-conversion: abort immediately and never emit the sample.
    begin
      int seen;
      @(negedge clk);
      in_valid = 1'b1;
      in_fixed = 16'd1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_state", {30'd0, out_valid, out_ready}, 32'b01);
      chk("abort_float", out_float, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (24) begin
        @(posedge clk); #1;
        if (out_valid) seen++;
      end
      chk("abort_noresult", 32'(seen), 32'd0);
      chk("abort_float_after", out_float, 32'h0);
    end

    conv("after_rst", 16'd100, 32'h42C8_0000, 6);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
